// File: rtl/mux8_bus_arbiter.sv
// ============================================================================
// mux8_bus_arbiter : round-robin, burst-bounded arbiter for one 16-bit port
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux8_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       out_valid,
  output logic [7:0] ack,
  output logic       busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [7:0]       r_grant, w_grant_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic       w_beat;
  logic       w_release;
  logic [2:0] w_start;
  logic       w_found;
  logic [2:0] w_winner;

  assign busy      = (r_state == ST_BUSY);
  assign sel       = r_sel;
  assign grant     = r_grant;
  assign out_valid = busy && req[r_sel];
  assign w_beat    = out_valid && out_ready;
  assign ack       = w_beat ? (8'd1 << r_sel) : 8'd0;

  // A release restarts the search just past the current owner; idle uses ptr.
  assign w_start = (r_state == ST_BUSY) ? (r_sel + 3'd1) : r_ptr;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = w_start;
    for (int i = 7; i >= 0; i--) begin
      if (req[w_start + 3'(i)]) begin
        w_found  = 1'b1;
        w_winner = w_start + 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_release   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_sel_nxt   = w_winner;
          w_grant_nxt = 8'd1 << w_winner;
          w_cnt_nxt   = '0;
        end
      end

      ST_BUSY: begin
        if (!req[r_sel]) begin
          w_release = 1'b1;
        end else if (w_beat) begin
          if (r_cnt == C_LAST) begin
            w_release = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        // Hand over in the same cycle so back-to-back grants have no bubble.
        if (w_release) begin
          w_ptr_nxt = r_sel + 3'd1;
          w_cnt_nxt = '0;
          if (w_found) begin
            w_sel_nxt   = w_winner;
            w_grant_nxt = 8'd1 << w_winner;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 8'd0;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_grant <= 8'd0;
      r_ptr   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux8_bus_arbiter.sv
// ============================================================================
// tb_mux8_bus_arbiter : three burst sizes (4,1,2) under shared stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux8_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] req = 8'd0;
  logic       out_ready = 1'b0;

  logic [2:0] sel_o   [3];
  logic [7:0] grant_o [3];
  logic [7:0] ack_o   [3];
  logic       busy_o  [3];
  logic       ov_o    [3];

  always #5 clock = ~clock;

  mux8_bus_arbiter #(.MAX_BURST(4)) u_dut_b4 (
    .clock(clock), .reset_n(reset_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[0]), .grant(grant_o[0]), .out_valid(ov_o[0]), .ack(ack_o[0]), .busy(busy_o[0]));

  mux8_bus_arbiter #(.MAX_BURST(1)) u_dut_b1 (
    .clock(clock), .reset_n(reset_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[1]), .grant(grant_o[1]), .out_valid(ov_o[1]), .ack(ack_o[1]), .busy(busy_o[1]));

  mux8_bus_arbiter #(.MAX_BURST(2)) u_dut_b2 (
    .clock(clock), .reset_n(reset_n), .req(req), .out_ready(out_ready),
    .sel(sel_o[2]), .grant(grant_o[2]), .out_valid(ov_o[2]), .ack(ack_o[2]), .busy(busy_o[2]));

  int total = 0;
  int bad   = 0;

  // Reference: who owns the bus, where the rotation starts, beats used so far.
  int burst  [3] = '{4, 1, 2};
  bit m_busy [3];
  int m_sel  [3];
  int m_ptr  [3];
  int m_used [3];

  typedef struct {
    bit         rst_before;
    int         inst;
    logic [7:0] req;
    logic       rdy;
    logic [2:0] sel;
    logic [7:0] grant;
    logic [7:0] ack;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int k, input logic [2:0] s,
                         input logic [7:0] g, input logic [7:0] a);
    chk(name, {9'd0, sel_o[k], grant_o[k], ack_o[k]}, {9'd0, s, g, a});
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0; m_sel[k] = 0; m_ptr[k] = 0; m_used[k] = 0;
    end
  endtask

  task automatic check_models();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] eg, ea;
      logic       ev;
      eg = m_busy[k] ? (8'd1 << m_sel[k]) : 8'd0;
      ev = m_busy[k] && req[m_sel[k]];
      ea = (ev && out_ready) ? eg : 8'd0;
      chk($sformatf("model_b%0d", burst[k]),
          {11'd0, sel_o[k], grant_o[k], busy_o[k], ov_o[k], ack_o[k]},
          {11'd0, 3'(m_sel[k]), eg, m_busy[k], ev, ea});
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit search, found;
      search = 1'b0;
      if (!m_busy[k]) search = 1'b1;
      else if (!req[m_sel[k]]) search = 1'b1;
      else if (out_ready) begin
        m_used[k]++;
        if (m_used[k] == burst[k]) search = 1'b1;
      end
      if (m_busy[k] && search) m_ptr[k] = (m_sel[k] + 1) % 8;
      if (search) begin
        found = 1'b0;
        for (int j = 0; j < 8; j++)
          if (!found && req[(m_ptr[k] + j) % 8]) begin
            found = 1'b1;
            m_sel[k] = (m_ptr[k] + j) % 8;
          end
        m_busy[k] = found;
        m_used[k] = 0;
      end
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic rdy);
    req = r;
    out_ready = rdy;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input logic [7:0] r, input logic rdy);
    drive(r, rdy);
    check_models();
    advance();
  endtask

  // Asserted off-edge; outputs must clear before any clock arrives.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_b%0d", burst[k]),
          {11'd0, sel_o[k], grant_o[k], busy_o[k], ov_o[k], ack_o[k]}, 32'd0);
    model_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;

    // Single requester at burst 4: continuous acks across the re-grant.
    tbl.push_back('{1'b1, 0, 8'h04, 1'b1, 3'd0, 8'h00, 8'h00});
    for (int i = 0; i < 6; i++)
      tbl.push_back('{1'b0, 0, 8'h04, 1'b1, 3'd2, 8'h04, 8'h04});
    // All requesting at burst 1: strict rotation, one beat each.
    tbl.push_back('{1'b1, 1, 8'hFF, 1'b1, 3'd0, 8'h00, 8'h00});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1'b0, 1, 8'hFF, 1'b1, 3'(i % 8), 8'd1 << (i % 8), 8'd1 << (i % 8)});

    foreach (tbl[n]) begin
      if (tbl[n].rst_before) do_reset();
      drive(tbl[n].req, tbl[n].rdy);
      chk_out($sformatf("table%0d", n), tbl[n].inst, tbl[n].sel, tbl[n].grant, tbl[n].ack);
      check_models();
      advance();
    end

    // Stall with a live grant: everything must hold.
    do_reset();
    cycle(8'h20, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(8'h20, 1'b0);
      chk_out("stall_hold", 0, 3'd5, 8'h20, 8'h00);
      chk("stall_valid", {31'd0, ov_o[0]}, 32'd1);
      check_models();
      advance();
    end
    for (int i = 0; i < 6; i++) cycle(8'h20, 1'b1);

    // Withdrawal during a stall hands over without a beat.
    do_reset();
    cycle(8'h28, 1'b0);
    drive(8'h28, 1'b0);
    chk_out("wd_granted", 0, 3'd3, 8'h08, 8'h00);
    check_models();
    advance();
    drive(8'h20, 1'b0);
    check_models();
    advance();
    drive(8'h20, 1'b0);
    chk_out("wd_handover", 0, 3'd5, 8'h20, 8'h00);
    check_models();
    advance();

    // Burst 2 starting at 7, then wrap to 0.
    do_reset();
    cycle(8'h40, 1'b1);
    drive(8'h40, 1'b1);
    chk_out("wrap_sel6", 2, 3'd6, 8'h40, 8'h40);
    check_models();
    advance();
    cycle(8'h81, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(8'h81, 1'b1);
      chk_out("wrap_sel7", 2, 3'd7, 8'h80, 8'h80);
      check_models();
      advance();
    end
    drive(8'h81, 1'b1);
    chk_out("wrap_sel0", 2, 3'd0, 8'h01, 8'h01);
    check_models();
    advance();

    // Reset landing mid-burst, then a fresh request after release.
    do_reset();
    cycle(8'h04, 1'b1);
    drive(8'h04, 1'b1);
    chk_out("pre_abort", 0, 3'd2, 8'h04, 8'h04);
    do_reset();
    drive(8'h01, 1'b1);
    chk_out("post_rst_idle", 0, 3'd0, 8'h00, 8'h00);
    check_models();
    advance();
    drive(8'h01, 1'b1);
    chk_out("post_rst_grant", 0, 3'd0, 8'h01, 8'h01);
    check_models();
    advance();

    // Random traffic against the reference model.
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 2000; i++) begin
        case ($urandom_range(0, 4))
          0: r = 8'($urandom) & 8'($urandom);
          1: r = 8'd1 << $urandom_range(0, 7);
          2: r = 8'hFF;
          3: r = 8'($urandom);
          default: ;
        endcase
        if ($urandom_range(0, 249) == 0) begin
          drive(r, 1'b1);
          do_reset();
        end
        cycle(r, $urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
